bist_stumps_controller: RTL and testbench

//  Parametrised multi-chain (STUMPS) logic-BIST controller; successor to the single-chain controller.

---
 rtl/bist_pkg.sv | 50 +++++
 rtl/bist_stumps_controller_if.sv | 23 ++
 rtl/bist_prpg.sv | 36 +++
 rtl/bist_stumps_controller.sv | 159 +++++++++++++++
 tb/tb_bist_stumps_controller.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared types and step functions for the STUMPS logic-BIST controller.
// Functions work on a wide word so one copy serves every PRPG/MISR width.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } state_e;

  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  localparam logic [15:0] DEF_PRPG_POLY = 16'hB400;
  localparam logic [15:0] DEF_PRPG_SEED = 16'h0001;
  localparam logic [15:0] DEF_MISR_POLY = 16'hB400;

  // Right-shifting Galois LFSR step.
  function automatic word_t lfsr_next(word_t s, word_t poly);
    return (s >> 1) ^ (s[0] ? poly : '0);
  endfunction

  // Left-shifting MISR step of width w, folding in one parallel data word.
  function automatic word_t misr_next(word_t m, word_t poly, word_t data, int w);
    word_t mask;
    word_t fb;
    mask = (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
    fb   = (((m >> (w - 1)) & word_t'(1)) != '0) ? poly : '0;
    return ((m << 1) ^ fb ^ data) & mask;
  endfunction

  // Each chain XORs two LFSR taps spaced apart so neighbouring chains do not
  // receive shifted copies of the same stream.
  function automatic word_t phase_shift(word_t s, int w, int n);
    word_t r;
    word_t a;
    word_t b;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      a = s >> (i % w);
      b = s >> ((3 * i + 5) % w);
      if (i < n) r = r | (word_t'(a[0] ^ b[0]) << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/bist_stumps_controller_if.sv
// Scan-side and wrapper-side signals of the STUMPS controller.
interface bist_stumps_controller_if #(
  parameter int NUM_CHAINS = 4,
  parameter int MISR_W     = 16
);
  logic                  bistmode;
  logic [NUM_CHAINS-1:0] cut_sdo;
  logic                  cut_scanmode;
  logic [NUM_CHAINS-1:0] cut_sdi;
  logic [MISR_W-1:0]     signature;
  logic                  bistdone;
  logic                  bistpass;

  modport master (
    input  bistmode, cut_sdo,
    output cut_scanmode, cut_sdi, signature, bistdone, bistpass
  );

  modport slave (
    output bistmode, cut_sdo,
    input  cut_scanmode, cut_sdi, signature, bistdone, bistpass
  );
endinterface

// File: rtl/bist_prpg.sv
// Seeded PRPG with phase shifter; sdi_next_o is the chain data for the state
// the LFSR takes at the coming edge, so the parent can register it in step.
module bist_prpg
  import bist_pkg::*;
#(
  parameter int                NUM_CHAINS = 4,
  parameter int                PRPG_W     = 16,
  parameter logic [PRPG_W-1:0] PRPG_POLY  = PRPG_W'(DEF_PRPG_POLY),
  parameter logic [PRPG_W-1:0] PRPG_SEED  = PRPG_W'(DEF_PRPG_SEED)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  load_seed_i,
  output logic [NUM_CHAINS-1:0] sdi_next_o
);

  logic [PRPG_W-1:0] lfsr_q;
  logic [PRPG_W-1:0] lfsr_d;

  always_comb begin
    // NOTE: default first so every path assigns lfsr_d and no latch is inferred.
    lfsr_d = lfsr_q;
    if (load_seed_i) lfsr_d = PRPG_SEED;
    else if (en_i)   lfsr_d = PRPG_W'(lfsr_next(word_t'(lfsr_q), word_t'(PRPG_POLY)));
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (rst) lfsr_q <= PRPG_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign sdi_next_o = NUM_CHAINS'(phase_shift(word_t'(lfsr_d), PRPG_W, NUM_CHAINS));

endmodule

// File: rtl/bist_stumps_controller.sv
// Multi-chain STUMPS logic-BIST controller: PRPG-fed chains, MISR compaction
// (first unload masked), pattern counting and golden-signature compare.
module bist_stumps_controller
  import bist_pkg::*;
#(
  parameter int                NUM_CHAINS   = 4,
  parameter int                CHAIN_LEN    = 263,
  parameter int                NUM_PATTERNS = 2000,
  parameter int                CAPTURE_CYC  = 1,
  parameter int                PRPG_W       = 16,
  parameter logic [PRPG_W-1:0] PRPG_POLY    = PRPG_W'(DEF_PRPG_POLY),
  parameter logic [PRPG_W-1:0] PRPG_SEED    = PRPG_W'(DEF_PRPG_SEED),
  parameter int                MISR_W       = 16,
  parameter logic [MISR_W-1:0] MISR_POLY    = MISR_W'(DEF_MISR_POLY),
  parameter logic [MISR_W-1:0] GOLDEN_SIG   = '0
) (
  input logic                        clk,
  input logic                        rst,
  bist_stumps_controller_if.master   bist_if
);

  if (NUM_CHAINS < 1 || NUM_CHAINS > MISR_W || CHAIN_LEN < 2 || NUM_PATTERNS < 1 ||
      CAPTURE_CYC < 1 || PRPG_W > MAX_W || MISR_W > MAX_W || PRPG_SEED == '0) begin : g_param_check
    $error("bist_stumps_controller: parameter out of range");
  end

  localparam int CNT_MAX = (CHAIN_LEN > CAPTURE_CYC) ? CHAIN_LEN : CAPTURE_CYC;
  localparam int BIT_W   = $clog2(CNT_MAX);
  localparam int PAT_W   = $clog2(NUM_PATTERNS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] LAST_CAP  = BIT_W'(CAPTURE_CYC - 1);
  localparam logic [PAT_W-1:0] PAT_TOTAL = PAT_W'(NUM_PATTERNS);

  state_e                state_q;
  logic                  bistmode_q;
  logic                  seen_low_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [PAT_W-1:0]      pat_cnt_q;
  logic [PAT_W-1:0]      pat_cnt_d;
  logic [MISR_W-1:0]     misr_q;
  logic [MISR_W-1:0]     misr_d;
  logic                  scan_q;
  logic                  done_q;
  logic                  pass_q;
  logic [NUM_CHAINS-1:0] sdi_q;
  logic [NUM_CHAINS-1:0] sdi_next;
  logic                  start;
  logic                  abort;
  logic                  prpg_en;

  // seen_low_q stops a bistmode held high through reset from looking like a fresh edge.
  assign start     = (state_q == ST_IDLE) && bist_if.bistmode && !bistmode_q && seen_low_q;
  assign abort     = (state_q != ST_IDLE) && !bist_if.bistmode;
  assign prpg_en   = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
  assign pat_cnt_d = pat_cnt_q + PAT_W'(1);
  assign misr_d    = MISR_W'(misr_next(word_t'(misr_q), word_t'(MISR_POLY),
                                       word_t'(bist_if.cut_sdo), MISR_W));

  bist_prpg #(
    .NUM_CHAINS (NUM_CHAINS),
    .PRPG_W     (PRPG_W),
    .PRPG_POLY  (PRPG_POLY),
    .PRPG_SEED  (PRPG_SEED)
  ) u_prpg (
    .clk         (clk),
    .rst         (rst),
    .en_i        (prpg_en),
    .load_seed_i (start),
    .sdi_next_o  (sdi_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bistmode_q <= 1'b0;
      seen_low_q <= 1'b0;
      bit_cnt_q  <= '0;
      pat_cnt_q  <= '0;
      misr_q     <= '0;
      scan_q     <= 1'b0;
      sdi_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      bistmode_q <= bist_if.bistmode;
      if (!bist_if.bistmode) seen_low_q <= 1'b1;
      sdi_q <= sdi_next;
      if (abort) begin
        state_q   <= ST_IDLE;
        scan_q    <= 1'b0;
        sdi_q     <= '0;
        done_q    <= 1'b0;
        pass_q    <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q   <= ST_SHIFT;
              scan_q    <= 1'b1;
              misr_q    <= '0;
              pat_cnt_q <= '0;
              bit_cnt_q <= '0;
            end else begin
              sdi_q <= '0;
            end
          end
          ST_SHIFT: begin
            // The first load's unload carries unknown CUT state, so it is not compacted.
            if (pat_cnt_q != '0) misr_q <= misr_d;
            if (bit_cnt_q == LAST_BIT) begin
              state_q   <= ST_CAPTURE;
              scan_q    <= 1'b0;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
          ST_CAPTURE: begin
            if (bit_cnt_q == LAST_CAP) begin
              bit_cnt_q <= '0;
              pat_cnt_q <= pat_cnt_d;
              scan_q    <= 1'b1;
              state_q   <= (pat_cnt_d == PAT_TOTAL) ? ST_UNLOAD : ST_SHIFT;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
          ST_UNLOAD: begin
            misr_q <= misr_d;
            if (bit_cnt_q == LAST_BIT) begin
              state_q   <= ST_COMPARE;
              scan_q    <= 1'b0;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
          ST_COMPARE: begin
            pass_q  <= (misr_q == GOLDEN_SIG);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
          ST_DONE: begin
            state_q <= ST_DONE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bist_if.cut_scanmode = scan_q;
  assign bist_if.cut_sdi      = sdi_q;
  assign bist_if.signature    = misr_q;
  assign bist_if.bistdone     = done_q;
  assign bist_if.bistpass     = pass_q;

endmodule

// File: tb/tb_bist_stumps_controller.sv
// Scoreboard bench for bist_stumps_controller: the driver queues expected chain
// data, load lengths and final results; a monitor pops them as the DUT shows them.
module tb_bist_stumps_controller;

  localparam int NC     = 4;
  localparam int L      = 8;
  localparam int NP     = 3;
  localparam int CAP    = 1;
  localparam int SHIFTS = (NP + 1) * L;
  localparam int IN_CYC = NP * (L + CAP) + L;
  localparam int LAT    = IN_CYC + 1;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          lat;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [NC-1:0] exp_sdi[$];
  int            exp_len[$];
  res_t          exp_res[$];
  logic [NC-1:0] sdo_vec[0:IN_CYC-1];

  bist_stumps_controller_if #(.NUM_CHAINS(NC), .MISR_W(16)) bif ();

  bist_stumps_controller #(
    .NUM_CHAINS(NC), .CHAIN_LEN(L), .NUM_PATTERNS(NP), .CAPTURE_CYC(CAP),
    .PRPG_W(16), .PRPG_POLY(16'hB400), .PRPG_SEED(16'h0001),
    .MISR_W(16), .MISR_POLY(16'hB400), .GOLDEN_SIG(16'h0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bist_if (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] prpg_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [NC-1:0] shifter(input logic [15:0] s);
    logic [NC-1:0] r;
    logic [15:0]   a;
    logic [15:0]   b;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      a = s >> (i % 16);
      b = s >> ((3 * i + 5) % 16);
      r = r | (NC'(a[0] ^ b[0]) << i);
    end
    return r;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [NC-1:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'hB400 : 16'h0000) ^ 16'(d);
  endfunction

  // Signature after the first `upto` cycles of a run, counted from the first SHIFT cycle.
  function automatic logic [15:0] model_sig(input int upto);
    logic [15:0] sig;
    int          p;
    int          off;
    bit          absorb;
    sig = '0;
    for (int k = 0; k < upto; k++) begin
      p   = k / (L + CAP);
      off = k % (L + CAP);
      if (p < NP) absorb = (off < L) && (p != 0);
      else        absorb = (k - NP * (L + CAP)) < L;
      if (absorb) sig = misr_step(sig, sdo_vec[k]);
    end
    return sig;
  endfunction

  task automatic push_run_exp(input logic [15:0] sig, input logic pass);
    logic [15:0] s;
    res_t        r;
    s = 16'h0001;
    for (int j = 0; j < SHIFTS; j++) begin
      exp_sdi.push_back(shifter(s));
      s = prpg_step(s);
    end
    for (int j = 0; j <= NP; j++) exp_len.push_back(L);
    r.sig  = sig;
    r.pass = pass;
    r.lat  = LAT;
    exp_res.push_back(r);
  endtask

  task automatic flush_exp();
    exp_sdi.delete();
    exp_len.delete();
    exp_res.delete();
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    logic prev_scan = 1'b0;
    logic prev_done = 1'b0;
    bit   in_run    = 1'b0;
    int   run_len   = 0;
    int   cyc       = 0;
    int   t0        = 0;
    res_t r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst || !bif.bistmode) begin
        in_run  = 1'b0;
        run_len = 0;
      end else begin
        if (bif.cut_scanmode && !prev_scan && !in_run) begin
          in_run = 1'b1;
          t0     = cyc;
        end
        if (bif.cut_scanmode) begin
          run_len++;
          if (exp_sdi.size() == 0) check("sdi_unexpected", 1, 0);
          else check("sdi", bif.cut_sdi, exp_sdi.pop_front());
        end else if (prev_scan) begin
          if (exp_len.size() == 0) check("len_unexpected", 1, 0);
          else check("shift_len", run_len, exp_len.pop_front());
          run_len = 0;
        end
        if (bif.bistdone && !prev_done) begin
          if (exp_res.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            r = exp_res.pop_front();
            check("signature", bif.signature, r.sig);
            check("bistpass", bif.bistpass, r.pass);
            check("latency", cyc - t0, r.lat);
          end
          in_run = 1'b0;
        end
      end
      prev_scan = bif.cut_scanmode;
      prev_done = bif.bistdone;
    end
  end

  // mode: 0 all-zero, 1 ones during first load only, 2 single bit in pattern 2, 3 random.
  task automatic run_test(input int mode, input int abort_at, input int hold);
    logic [15:0] sig;
    logic        pass;
    bit          got;
    for (int k = 0; k < IN_CYC; k++) begin
      case (mode)
        0:       sdo_vec[k] = '0;
        1:       sdo_vec[k] = (k < L) ? '1 : '0;
        2:       sdo_vec[k] = (k == 2 * (L + CAP) + 2) ? NC'(4) : '0;
        default: sdo_vec[k] = NC'($urandom);
      endcase
    end
    sig  = model_sig(IN_CYC);
    pass = (sig == 16'h0000);
    push_run_exp(sig, pass);
    @(negedge clk);
    bif.bistmode = 1'b1;
    for (int k = 0; k < IN_CYC; k++) begin
      @(negedge clk);
      bif.cut_sdo = sdo_vec[k];
      if (k == abort_at) begin
        bif.bistmode = 1'b0;
        @(posedge clk);
        #1;
        check("abort_scanmode", bif.cut_scanmode, 0);
        check("abort_bistdone", bif.bistdone, 0);
        check("abort_sdi", bif.cut_sdi, 0);
        check("abort_sig_held", bif.signature, model_sig(abort_at));
        @(negedge clk);
        bif.cut_sdo = '0;
        flush_exp();
        return;
      end
    end
    @(negedge clk);
    bif.cut_sdo = '0;
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      @(posedge clk);
      #1;
      if (bif.bistdone) got = 1'b1;
    end
    check("done_seen", got, 1);
    if (mode == 2) check("sig_nonzero", bif.signature != 16'h0, 1);
    for (int h = 0; h < hold; h++) begin
      check("hold_done", bif.bistdone, 1);
      check("hold_pass", bif.bistpass, pass);
      check("hold_sig", bif.signature, sig);
      check("hold_scan", bif.cut_scanmode, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bif.bistmode = 1'b0;
    @(posedge clk);
    #1;
    check("exit_done", bif.bistdone, 0);
    check("exit_pass", bif.bistpass, 0);
    check("exit_scan", bif.cut_scanmode, 0);
    check("exit_sig_held", bif.signature, sig);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    rst          = 1'b1;
    bif.bistmode = 1'b0;
    bif.cut_sdo  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_scan", bif.cut_scanmode, 0);
    check("rst_sdi", bif.cut_sdi, 0);
    check("rst_sig", bif.signature, 0);
    check("rst_done", bif.bistdone, 0);
    check("rst_pass", bif.bistpass, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of SHIFT with bistmode held high.
    push_run_exp(16'h0, 1'b1);
    bif.bistmode = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("midrst_scan", bif.cut_scanmode, 0);
      check("midrst_sdi", bif.cut_sdi, 0);
      check("midrst_sig", bif.signature, 0);
      check("midrst_done", bif.bistdone, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    flush_exp();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("no_start_held_high", bif.cut_scanmode, 0);
    end
    @(negedge clk);
    bif.bistmode = 1'b0;

    run_test(0, -1, 2);
    run_test(1, -1, 2);
    run_test(2, -1, 2);
    run_test(3, 15, 0);
    run_test(3, -1, 20);
    run_test(3, -1, 2);
    run_test(3, -1, 2);

    repeat (3) @(negedge clk);
    check("pending_results", exp_res.size(), 0);
    check("pending_sdi", exp_sdi.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
